park_disp_ctrl: RTL and testbench



---
 rtl/park_pkg.sv | 22 ++
 rtl/park_disp_ctrl_if.sv | 12 +
 rtl/disp_scan_timer.sv | 27 ++
 rtl/park_disp_ctrl.sv | 96 +++++++++
 tb/tb_park_disp_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/park_pkg.sv
// park_pkg: character codes shared with svn_seg, controller state encoding and anode helper.
package park_pkg;
  localparam logic [3:0] CH_O    = 4'd0;
  localparam logic [3:0] CH_1    = 4'd1;
  localparam logic [3:0] CH_2    = 4'd2;
  localparam logic [3:0] CH_3    = 4'd3;
  localparam logic [3:0] CH_4    = 4'd4;
  localparam logic [3:0] CH_DASH = 4'd5;
  localparam logic [3:0] CH_E    = 4'd6;
  localparam logic [3:0] CH_N    = 4'd7;
  localparam logic [3:0] CH_F    = 4'd8;
  localparam logic [3:0] CH_U    = 4'd9;
  localparam logic [3:0] CH_L    = 4'd10;
  localparam logic [3:0] CH_P    = 4'd11;

  typedef enum logic [1:0] {ST_OPEN, ST_FREE, ST_FULL} state_t;

  // Digit index 0 is the leftmost digit, driven by an[3].
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction
endpackage

// File: rtl/park_disp_ctrl_if.sv
// park_disp_ctrl_if: sensor pulses in, display code/anodes and occupancy status out.
interface park_disp_ctrl_if;
  logic       car_in;
  logic       car_out;
  logic [3:0] code;
  logic [3:0] an;
  logic [2:0] occupancy;
  logic       full;

  modport master (output car_in, car_out, input code, an, occupancy, full);
  modport slave  (input car_in, car_out, output code, an, occupancy, full);
endinterface

// File: rtl/disp_scan_timer.sv
// disp_scan_timer: digit-slot prescaler and 2-bit digit index with tick and frame_end strobes.
module disp_scan_timer #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] idx,
  output logic       tick,
  output logic       frame_end
);
  localparam int W = $clog2(REFRESH_DIV);

  logic [W-1:0] presc;

  assign tick      = presc == W'(REFRESH_DIV - 1);
  assign frame_end = tick && idx == 2'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      idx   <= idx + {1'b0, tick};
    end
  end
endmodule

// File: rtl/park_disp_ctrl.sv
// park_disp_ctrl: car-park occupancy tracker driving a 4-digit multiplexed status display.
module park_disp_ctrl
  import park_pkg::*;
#(
  parameter int CAPACITY    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int MSG_HOLD    = 50
) (
  input logic             clk,
  input logic             rst,
  park_disp_ctrl_if.slave bus
);
  localparam int HW = ($clog2(MSG_HOLD + 1) < 1) ? 1 : $clog2(MSG_HOLD + 1);

  logic [1:0]    idx;
  logic          tick, frame_end;
  logic [2:0]    occ, occ_nxt;
  logic          full_r, inc, dec;
  state_t        state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [3:0]    ch, disp_code, disp_an;

  disp_scan_timer #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .tick     (tick),
    .frame_end(frame_end)
  );

  assign inc     = bus.car_in && !bus.car_out && occ < 3'(CAPACITY);
  assign dec     = bus.car_out && !bus.car_in && occ != 3'd0;
  assign occ_nxt = occ + {2'b0, inc} - {2'b0, dec};

  // full tracks the value occupancy is about to take so both flip on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      full_r <= 1'b0;
    end else begin
      occ    <= occ_nxt;
      full_r <= occ_nxt == 3'(CAPACITY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OPEN;
      hold  <= HW'(MSG_HOLD);
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
    end
  end

  // The OPEN hold expires on the frame_end that takes the counter to zero.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    if (full_r) begin
      state_nxt = ST_FULL;
    end else if (state == ST_FULL) begin
      state_nxt = ST_OPEN;
      hold_nxt  = HW'(MSG_HOLD);
    end else if (state == ST_OPEN && tick && frame_end) begin
      hold_nxt  = hold - 1'b1;
      state_nxt = (hold <= HW'(1)) ? ST_FREE : ST_OPEN;
    end
  end

  always_comb begin
    ch = CH_DASH;
    case (state)
      ST_OPEN: ch = idx == 2'd0 ? CH_O : idx == 2'd1 ? CH_P : idx == 2'd2 ? CH_E : CH_N;
      ST_FREE: ch = idx == 2'd0 ? CH_P : idx == 2'd3 ? 4'(CAPACITY) - {1'b0, occ} : CH_DASH;
      ST_FULL: ch = idx == 2'd0 ? CH_F : idx == 2'd1 ? CH_U : CH_L;
      default: ch = CH_DASH;
    endcase
  end

  // code and an share one register stage so a digit never shows its neighbour's character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_code <= CH_DASH;
      disp_an   <= 4'b1111;
    end else begin
      disp_code <= ch;
      disp_an   <= an_sel(idx);
    end
  end

  assign bus.code      = disp_code;
  assign bus.an        = disp_an;
  assign bus.occupancy = occ;
  assign bus.full      = full_r;
endmodule

// File: tb/tb_park_disp_ctrl.sv
// tb_park_disp_ctrl: directed and random pulse scenarios checked against a message-level reference model.
module tb_park_disp_ctrl;
  localparam int CAP = 4;
  localparam int RD  = 4;
  localparam int MH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  park_disp_ctrl_if bus ();

  park_disp_ctrl #(.CAPACITY(CAP), .REFRESH_DIV(RD), .MSG_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         m_occ, m_hold, cyc;
  bit         m_full;
  string      m_mode;
  logic [3:0] m_code, m_an;

  function automatic logic [3:0] msg_char(input string mode, input int occ, input int pos);
    if (mode == "OPEN") return pos == 0 ? 4'd0 : pos == 1 ? 4'd11 : pos == 2 ? 4'd6 : 4'd7;
    if (mode == "FULL") return pos == 0 ? 4'd8 : pos == 1 ? 4'd9 : 4'd10;
    return pos == 0 ? 4'd11 : pos == 3 ? 4'(CAP - occ) : 4'd5;
  endfunction

  // Reference: cyc counts edges since reset; the slot shown is cyc/RD mod 4, one edge late.
  always @(posedge clk or posedge rst) begin
    int pos, nocc;
    bit fe;
    if (rst) begin
      m_occ = 0; m_full = 0; m_mode = "OPEN"; m_hold = MH; cyc = 0;
      m_code = 4'd5; m_an = 4'hF;
    end else begin
      pos = (cyc / RD) % 4;
      m_code = msg_char(m_mode, m_occ, pos);
      m_an = 4'hF;
      m_an[3-pos] = 1'b0;
      fe = (cyc % RD == RD - 1) && pos == 3;
      if (m_full) m_mode = "FULL";
      else if (m_mode == "FULL") begin m_mode = "OPEN"; m_hold = MH; end
      else if (m_mode == "OPEN" && fe) begin
        m_hold--;
        if (m_hold == 0) m_mode = "FREE";
      end
      nocc = m_occ;
      if (bus.car_in && !bus.car_out && m_occ < CAP) nocc++;
      if (bus.car_out && !bus.car_in && m_occ > 0) nocc--;
      m_occ = nocc;
      m_full = nocc == CAP;
      cyc++;
    end
  end

  task automatic test_reset();
    logic [3:0] open_c [4] = '{4'd0, 4'd11, 4'd6, 4'd7};
    logic [3:0] free_c [4] = '{4'd11, 4'd5, 4'd5, 4'd4};
    logic [3:0] want;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.an !== 4'b1111 || bus.code !== 4'd5 || bus.occupancy !== 3'd0 || bus.full !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: an=%b code=%0d occ=%0d full=%b want an=1111 code=5 occ=0 full=0",
               bus.an, bus.code, bus.occupancy, bus.full);
    end
    rst = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      want = (k <= 32) ? open_c[((k - 1) / 4) % 4] : free_c[((k - 1) / 4) % 4];
      total++;
      if (bus.code !== want || bus.an !== ~(4'b1000 >> (((k - 1) / 4) % 4))) begin
        bad++;
        $display("FAIL reset_seq k=%0d: code=%0d an=%b want code=%0d", k, bus.code, bus.an, want);
      end
      total++;
      if (bus.code !== m_code || bus.an !== m_an) begin
        bad++;
        $display("FAIL reset_model k=%0d: code=%0d an=%b want code=%0d an=%b", k, bus.code, bus.an, m_code, m_an);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if ({bus.code, bus.an, bus.occupancy, bus.full} !== {m_code, m_an, 3'(m_occ), m_full}) begin
        bad++;
        $display("FAIL fill i=%0d: code=%0d an=%b occ=%0d full=%b want code=%0d an=%b occ=%0d full=%b",
                 i, bus.code, bus.an, bus.occupancy, bus.full, m_code, m_an, m_occ, m_full);
      end
      if (i == 10) begin
        total++;
        if (bus.occupancy !== 3'd4 || bus.full !== 1'b1) begin
          bad++;
          $display("FAIL fill_count: occ=%0d full=%b want occ=4 full=1", bus.occupancy, bus.full);
        end
      end
      if (i == 39) begin
        total++;
        if (bus.code < 4'd8 || bus.code > 4'd10) begin
          bad++;
          $display("FAIL fill_msg: code=%0d want one of 8,9,10", bus.code);
        end
      end
      bus.car_in = (i % 3 == 0) && i < 12;
    end
  endtask

  task automatic test_full();
    int n;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      total++;
      if ({bus.code, bus.an, bus.occupancy, bus.full} !== {m_code, m_an, 3'(m_occ), m_full}) begin
        bad++;
        $display("FAIL full i=%0d: code=%0d an=%b occ=%0d full=%b want code=%0d an=%b occ=%0d full=%b",
                 i, bus.code, bus.an, bus.occupancy, bus.full, m_code, m_an, m_occ, m_full);
      end
      if (i == 3) begin
        total++;
        if (bus.occupancy !== 3'd4 || bus.full !== 1'b1) begin
          bad++;
          $display("FAIL full_saturate: occ=%0d full=%b want occ=4 full=1", bus.occupancy, bus.full);
        end
      end
      if (i == 10) begin
        total++;
        if (bus.occupancy !== 3'd3 || bus.full !== 1'b0) begin
          bad++;
          $display("FAIL full_leave: occ=%0d full=%b want occ=3 full=0", bus.occupancy, bus.full);
        end
      end
      bus.car_in  = i == 0;
      bus.car_out = i == 8;
    end
    n = 0;
    while (bus.an !== 4'b1110 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (bus.an !== 4'b1110 || bus.code !== 4'd1) begin
      bad++;
      $display("FAIL full_free_digit: an=%b code=%0d want an=1110 code=1", bus.an, bus.code);
    end
  endtask

  task automatic test_bounds();
    int n;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      total++;
      if ({bus.code, bus.an, bus.occupancy, bus.full} !== {m_code, m_an, 3'(m_occ), m_full}) begin
        bad++;
        $display("FAIL bounds i=%0d: code=%0d an=%b occ=%0d full=%b want code=%0d an=%b occ=%0d full=%b",
                 i, bus.code, bus.an, bus.occupancy, bus.full, m_code, m_an, m_occ, m_full);
      end
      if (i == 5) begin
        total++;
        if (bus.occupancy !== 3'd2) begin
          bad++;
          $display("FAIL bounds_both: occ=%0d want 2", bus.occupancy);
        end
      end
      if (i == 14) begin
        total++;
        if (bus.occupancy !== 3'd0) begin
          bad++;
          $display("FAIL bounds_empty: occ=%0d want 0", bus.occupancy);
        end
      end
      bus.car_in  = i == 3 || i == 15 || i == 18 || i == 21 || i == 24 || i == 46;
      bus.car_out = i == 0 || i == 3 || i == 6 || i == 9 || i == 12 || i == 40;
    end
    n = 0;
    while (bus.an !== 4'b0111 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (bus.an !== 4'b0111 || bus.code !== 4'd8) begin
      bad++;
      $display("FAIL bounds_open_abort: an=%b code=%0d want an=0111 code=8", bus.an, bus.code);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.an !== 4'b1111 || bus.code !== 4'd5 || bus.occupancy !== 3'd0 || bus.full !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: an=%b code=%0d occ=%0d full=%b want an=1111 code=5 occ=0 full=0",
               bus.an, bus.code, bus.occupancy, bus.full);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (bus.an !== 4'b0111 || bus.code !== 4'd0) begin
          bad++;
          $display("FAIL async_restart: an=%b code=%0d want an=0111 code=0", bus.an, bus.code);
        end
      end
      total++;
      if ({bus.code, bus.an, bus.occupancy, bus.full} !== {m_code, m_an, 3'(m_occ), m_full}) begin
        bad++;
        $display("FAIL async_model i=%0d: code=%0d an=%b occ=%0d want code=%0d an=%b occ=%0d",
                 i, bus.code, bus.an, bus.occupancy, m_code, m_an, m_occ);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_an = bus.an;
    int last = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      total++;
      if ({bus.code, bus.an, bus.occupancy, bus.full} !== {m_code, m_an, 3'(m_occ), m_full}) begin
        bad++;
        $display("FAIL random i=%0d: code=%0d an=%b occ=%0d full=%b want code=%0d an=%b occ=%0d full=%b",
                 i, bus.code, bus.an, bus.occupancy, bus.full, m_code, m_an, m_occ, m_full);
      end
      total++;
      if (!$onehot(~bus.an) || bus.code > 4'd11) begin
        bad++;
        $display("FAIL random_legal i=%0d: an=%b code=%0d want one low anode and code<=11", i, bus.an, bus.code);
      end
      if (bus.an !== prev_an) begin
        if (last >= 0) begin
          total++;
          if (i - last != RD) begin
            bad++;
            $display("FAIL random_period i=%0d: anode slot lasted %0d cycles want %0d", i, i - last, RD);
          end
        end
        last = i;
        prev_an = bus.an;
      end
      bus.car_in  = $urandom_range(0, 5) == 0;
      bus.car_out = $urandom_range(0, 5) == 0;
    end
    @(negedge clk);
    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
    test_reset();
    test_fill();
    test_full();
    test_bounds();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
